// File: rtl/fft_pkg.sv
//============================================================================
// Module      : fft_pkg
// Description : Shared FFT addressing helpers: FSM state encoding, operand
//               address bit-insertion and DIF twiddle exponent.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package fft_pkg;

    localparam int c_max_aw = 16;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_fin   = 2'd3;

    // Splits val at bit pos and inserts bit_val there (the butterfly partner bit).
    function automatic logic [c_max_aw-1:0] insert_bit(
        input logic [c_max_aw-1:0] val,
        input int unsigned         pos,
        input logic                bit_val
    );
        logic [c_max_aw-1:0] low_mask;
        low_mask = (c_max_aw'(1) << pos) - c_max_aw'(1);
        return ((val & ~low_mask) << 1) | (val & low_mask) | (c_max_aw'(bit_val) << pos);
    endfunction

    function automatic logic [c_max_aw-1:0] twiddle_exp(
        input logic [c_max_aw-1:0] j,
        input int unsigned         pos,
        input int unsigned         stg
    );
        logic [c_max_aw-1:0] low_mask;
        low_mask = (c_max_aw'(1) << pos) - c_max_aw'(1);
        return (j & low_mask) << stg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bu_dly.sv
//============================================================================
// Module      : bu_dly
// Description : LAT-deep resettable shift register carrying the read
//               {valid, addr0, addr1} tuple to the write-back port.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module bu_dly #(
    parameter int LAT = 2,
    parameter int AW  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [AW-1:0] i_addr0,
    input  logic [AW-1:0] i_addr1,
    output logic          o_valid,
    output logic [AW-1:0] o_addr0,
    output logic [AW-1:0] o_addr1
);

    localparam int c_w = 1 + 2 * AW;

    logic [c_w-1:0] r_sr [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                r_sr[i] <= '0;
            end
        end else begin
            r_sr[0] <= {i_valid, i_addr0, i_addr1};
            for (int i = 1; i < LAT; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign {o_valid, o_addr0, o_addr1} = r_sr[LAT-1];

endmodule

`default_nettype wire

// File: rtl/bu_sched.sv
//============================================================================
// Module      : bu_sched
// Description : In-place radix-2 DIF butterfly scheduler: issues operand
//               reads, twiddle exponents and delayed write-backs per stage.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module bu_sched
    import fft_pkg::*;
#(
    parameter int N_LOG = 4,
    parameter int LAT   = 2,
    parameter int AW    = N_LOG,
    localparam int c_sw = (N_LOG > 1) ? $clog2(N_LOG) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr0,
    output logic [AW-1:0]   rd_addr1,
    output logic [c_sw-1:0] stage,
    output logic [AW-2:0]   tw_idx,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr0,
    output logic [AW-1:0]   wr_addr1
);

    localparam int c_jw = (N_LOG > 1) ? (N_LOG - 1) : 1;
    localparam int c_cw = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [c_jw-1:0] c_j_last   = c_jw'((1 << (N_LOG - 1)) - 1);
    localparam logic [c_sw-1:0] c_stg_last = c_sw'(N_LOG - 1);
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(LAT - 1);

    logic [1:0]      r_state;
    logic [c_sw-1:0] r_stage;
    logic [c_jw-1:0] r_j;
    logic [c_cw-1:0] r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_rd_en;
    logic [AW-1:0]   r_rd_addr0;
    logic [AW-1:0]   r_rd_addr1;
    logic [AW-2:0]   r_tw;

    logic [c_sw-1:0] w_ld_stage;
    logic [c_jw-1:0] w_ld_j;
    int unsigned     w_pos;
    logic [AW-1:0]   w_a0;
    logic [AW-1:0]   w_a1;
    logic [AW-2:0]   w_tw;

    // Outputs are registered, so the pair about to be presented is computed one cycle ahead.
    always_comb begin
        w_ld_stage = r_stage;
        w_ld_j     = r_j + 1'b1;
        if (r_state == c_st_idle) begin
            w_ld_stage = '0;
            w_ld_j     = '0;
        end else if (r_state == c_st_drain) begin
            w_ld_stage = r_stage + 1'b1;
            w_ld_j     = '0;
        end
        w_pos = N_LOG - 1 - int'(w_ld_stage);
        w_a0  = AW'(insert_bit(c_max_aw'(w_ld_j), w_pos, 1'b0));
        w_a1  = AW'(insert_bit(c_max_aw'(w_ld_j), w_pos, 1'b1));
        w_tw  = (AW-1)'(twiddle_exp(c_max_aw'(w_ld_j), w_pos, int'(w_ld_stage)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_stage    <= '0;
            r_j        <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_addr0 <= '0;
            r_rd_addr1 <= '0;
            r_tw       <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state    <= c_st_run;
                        r_busy     <= 1'b1;
                        r_stage    <= w_ld_stage;
                        r_j        <= w_ld_j;
                        r_rd_en    <= 1'b1;
                        r_rd_addr0 <= w_a0;
                        r_rd_addr1 <= w_a1;
                        r_tw       <= w_tw;
                    end
                end
                c_st_run: begin
                    if (r_j == c_j_last) begin
                        r_state <= c_st_drain;
                        r_rd_en <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_j        <= w_ld_j;
                        r_rd_en    <= 1'b1;
                        r_rd_addr0 <= w_a0;
                        r_rd_addr1 <= w_a1;
                        r_tw       <= w_tw;
                    end
                end
                c_st_drain: begin
                    // LAT idle cycles let the last write of this stage land before the next stage reads.
                    if (r_cnt == c_cnt_last) begin
                        if (r_stage == c_stg_last) begin
                            r_state <= c_st_fin;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= c_st_run;
                            r_stage    <= w_ld_stage;
                            r_j        <= w_ld_j;
                            r_rd_en    <= 1'b1;
                            r_rd_addr0 <= w_a0;
                            r_rd_addr1 <= w_a1;
                            r_tw       <= w_tw;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_fin: begin
                    r_state <= c_st_idle;
                    r_done  <= 1'b0;
                    r_j     <= '0;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    bu_dly #(
        .LAT (LAT),
        .AW  (AW)
    ) u_bu_dly (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_rd_en),
        .i_addr0 (r_rd_addr0),
        .i_addr1 (r_rd_addr1),
        .o_valid (wr_en),
        .o_addr0 (wr_addr0),
        .o_addr1 (wr_addr1)
    );

    assign busy     = r_busy;
    assign done     = r_done;
    assign rd_en    = r_rd_en;
    assign rd_addr0 = r_rd_addr0;
    assign rd_addr1 = r_rd_addr1;
    assign stage    = r_stage;
    assign tw_idx   = r_tw;

endmodule

`default_nettype wire

// File: tb/tb_bu_sched.sv
//============================================================================
// Module      : tb_bu_sched
// Description : Scoreboard bench for bu_sched with a RAM + modular butterfly
//               in the loop, checked against a direct N-point transform.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bu_sched;

    localparam int N_LOG   = 4;
    localparam int LAT     = 2;
    localparam int AW      = N_LOG;
    localparam int N       = 1 << N_LOG;
    localparam int HALF    = N / 2;
    localparam int RUN_LEN = N_LOG * (HALF + LAT);
    localparam int P       = 17;   // prime field, 3 has order 16 = N
    localparam int G       = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
    logic [1:0]    stage;
    logic [AW-2:0] tw_idx;

    bu_sched #(.N_LOG(N_LOG), .LAT(LAT), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .stage    (stage),
        .tw_idx   (tw_idx),
        .wr_en    (wr_en),
        .wr_addr0 (wr_addr0),
        .wr_addr1 (wr_addr1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int a0;
        int a1;
        int st;
        int tw;
    } ev_t;

    ev_t rd_q[$];
    ev_t wr_q[$];
    int  done_q[$];
    int  bu_q0[$];
    int  bu_q1[$];
    int  mem[N];
    int  gold[N];
    int  cyc   = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  m_acc = -1000;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int modpow(input int b, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % P;
        return r;
    endfunction

    function automatic int bitrev(input int v);
        int r;
        r = 0;
        for (int i = 0; i < N_LOG; i++) r = r | (((v >> i) & 1) << (N_LOG - 1 - i));
        return r;
    endfunction

    function automatic void check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, got, exp, cyc);
        end
    endfunction

    // Reference: every partner pair (a, a + 2^p) with bit p of a clear, in ascending a.
    task automatic accept(input int e);
        ev_t ev;
        int  p, k;
        m_acc = e;
        for (int i = 0; i < N; i++) mem[i] = $urandom_range(0, P - 1);
        for (int kk = 0; kk < N; kk++) begin
            gold[kk] = 0;
            for (int n = 0; n < N; n++) gold[kk] = (gold[kk] + mem[n] * modpow(G, (n * kk) % N)) % P;
        end
        for (int s = 0; s < N_LOG; s++) begin
            p = N_LOG - 1 - s;
            k = 0;
            for (int a = 0; a < N; a++) begin
                if (((a >> p) & 1) == 0) begin
                    ev.cyc = e + s * (HALF + LAT) + k;
                    ev.a0  = a;
                    ev.a1  = a + (1 << p);
                    ev.st  = s;
                    ev.tw  = ((a % (1 << p)) << s) % (1 << (AW - 1));
                    rd_q.push_back(ev);
                    ev.cyc = ev.cyc + LAT;
                    wr_q.push_back(ev);
                    k++;
                end
            end
        end
        done_q.push_back(e + RUN_LEN);
    endtask

    task automatic try_start();
        int e;
        @(negedge clk);
        start = 1'b1;
        e = cyc + 1;
        if (m_acc < 0 || e >= m_acc + RUN_LEN + 2) accept(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic flush_model();
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        bu_q0.delete();
        bu_q1.delete();
        m_acc = -1000;
    endtask

    task automatic check_zero(input string nm);
        check(nm, int'({busy, done, rd_en, wr_en, rd_addr0, rd_addr1, stage, tw_idx, wr_addr0, wr_addr1}), 0);
    endtask

    // Monitor: writes are applied before reads so the RAM model sees committed data.
    always @(negedge clk) begin
        ev_t ev;
        int  a, b;
        check("busy", int'(busy), int'(m_acc >= 0 && cyc >= m_acc && cyc < m_acc + RUN_LEN));
        if (wr_en) begin
            n_cmp++;
            if (wr_q.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected: got a0=%0d a1=%0d at cyc %0d, required no write", wr_addr0, wr_addr1, cyc);
            end else begin
                ev = wr_q.pop_front();
                if (ev.cyc != cyc || ev.a0 != int'(wr_addr0) || ev.a1 != int'(wr_addr1)) begin
                    n_bad++;
                    $display("FAIL wr: got cyc=%0d a0=%0d a1=%0d, required cyc=%0d a0=%0d a1=%0d",
                             cyc, wr_addr0, wr_addr1, ev.cyc, ev.a0, ev.a1);
                end
            end
            if (bu_q0.size() > 0) begin
                mem[wr_addr0] = bu_q0.pop_front();
                mem[wr_addr1] = bu_q1.pop_front();
            end
        end
        if (rd_en) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_bad++;
                $display("FAIL rd_unexpected: got a0=%0d a1=%0d at cyc %0d, required no read", rd_addr0, rd_addr1, cyc);
            end else begin
                ev = rd_q.pop_front();
                if (ev.cyc != cyc || ev.a0 != int'(rd_addr0) || ev.a1 != int'(rd_addr1) ||
                    ev.st != int'(stage) || ev.tw != int'(tw_idx)) begin
                    n_bad++;
                    $display("FAIL rd: got cyc=%0d a0=%0d a1=%0d st=%0d tw=%0d, required cyc=%0d a0=%0d a1=%0d st=%0d tw=%0d",
                             cyc, rd_addr0, rd_addr1, stage, tw_idx, ev.cyc, ev.a0, ev.a1, ev.st, ev.tw);
                end
            end
            a = mem[rd_addr0];
            b = mem[rd_addr1];
            bu_q0.push_back((a + b) % P);
            bu_q1.push_back((((a - b) % P + P) % P * modpow(G, int'(tw_idx))) % P);
        end
        if (done) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                check("done_cycle", cyc, done_q.pop_front());
                for (int k = 0; k < N; k++) check($sformatf("result_X%0d", k), mem[bitrev(k)], gold[k]);
            end
        end
    end

    initial begin
        int e0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset_state");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Full run with starts during busy and during done.
        try_start();
        e0 = m_acc;
        wait_until(e0 + 3);
        try_start();
        wait_until(e0 + 39);
        try_start();
        wait_until(e0 + RUN_LEN + 10);

        // Reset mid-run, then a clean run.
        try_start();
        e0 = m_acc;
        wait_until(e0 + 12);
        @(posedge clk);
        #2 rst_n = 1'b0;
        flush_model();
        #1 check_zero("midrun_reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        try_start();
        wait_until(m_acc + RUN_LEN + 3);

        // Randomized start timing.
        for (int r = 0; r < 5; r++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            try_start();
            for (int k = 0; k < 3; k++) begin
                wait_until(cyc + $urandom_range(1, 15));
                try_start();
            end
            wait_until(m_acc + RUN_LEN + 3);
        end

        repeat (5) @(negedge clk);
        check("queues_drained", rd_q.size() + wr_q.size() + done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: got timeout at cyc %0d, required completion", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/bu_sched.md
BU_SCHED -- requirements
Module: bu_sched

Interface
REQ-001 Parameter N_LOG, default 4, meaning log2 of transform length N (N = 2^N_LOG points, N/2 butterflies per stage).
REQ-002 Parameter LAT, default 2, meaning cycles from rd_en issue to the matching BU result being ready for write-back (RAM read plus BU register), minimum 1.
REQ-003 Parameter AW, default N_LOG, meaning the address width.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  a one-cycle request to run a full N-point in-place DIF pass.
REQ-007 busy  output  1  high from start acceptance until done.
REQ-008 done  output  1  a one-cycle pulse when the last write-back completes.
REQ-009 rd_en  output  1  reads the operand pair for BU R0_in/R1_in.
REQ-010 rd_addr0 / rd_addr1  output  AW  the operand pair addresses.
REQ-011 stage  output  N_LOG-clog  the current stage index, valid with rd_en.
REQ-012 tw_idx  output  AW-1  the twiddle exponent, valid with rd_en.
REQ-013 wr_en  output  1  writes back BU R0_out/R1_out.
REQ-014 wr_addr0 / wr_addr1  output  AW  the write-back addresses for R0_out/R1_out.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN, DRAIN and FIN; all outputs are registered.
REQ-016 IDLE: start=1 SHALL go to RUN with stage=0 and j=0 and set busy=1; start=0 SHALL hold.
REQ-017 RUN: each cycle SHALL assert rd_en for pair j and increment j; when j=N/2-1 it SHALL go to DRAIN.
REQ-018 DRAIN: the FSM SHALL wait exactly LAT cycles (rd_en=0); then, if stage<N_LOG-1, it SHALL increment stage, clear j and return to RUN; otherwise it SHALL go to FIN.
REQ-019 FIN: the block SHALL pulse done for 1 cycle, clear busy and return to IDLE.
REQ-020 Addressing for stage s, with bit position p=N_LOG-1-s: rd_addr0 SHALL be j with a 0 inserted at bit p, and rd_addr1 SHALL be the same value with a 1 inserted at bit p.
REQ-021 tw_idx SHALL equal (j mod 2^p) << s and be truncated to AW-1 bits.
REQ-022 wr_en, wr_addr0 and wr_addr1 SHALL equal rd_en, rd_addr0 and rd_addr1 delayed by exactly LAT cycles.
REQ-023 The DRAIN gap SHALL guarantee that no read of stage s+1 precedes the final write of stage s (no RAW hazard).
REQ-024 Total latency: done SHALL assert exactly N_LOG*(N/2+LAT) cycles after the edge that accepted start.
REQ-025 start while busy=1 SHALL be ignored, with no queuing.
REQ-026 start in the same cycle as the done pulse SHALL be ignored; a new run is accepted only from IDLE.
REQ-027 j and stage SHALL wrap only through the explicit transitions above and never count past N/2-1 or N_LOG-1.

Reset
REQ-028 rst_n=0 at any time, including mid-run, SHALL force IDLE, clear busy, done, rd_en and wr_en, and set all addresses, stage, tw_idx and j to 0.
REQ-029 Reset SHALL flush the delay line, so no wr_en appears after reset release unless a new start is accepted.
REQ-030 The first start SHALL be accepted on the first rising edge after reset release.

Structure
REQ-031 The state encoding and the address-insert and twiddle functions SHALL reside in the shared package fft_pkg, so address generators in other stages reuse them.
REQ-032 One sub-module SHALL be used: bu_dly, a LAT-deep resettable shift register carrying {valid, addr0, addr1}.
REQ-033 BU itself SHALL remain outside this block, and the datapath SHALL be untouched.

Verification (N_LOG=4, LAT=2)
REQ-034 Start pulse after reset -> busy=1 next cycle; stage 0 reads (0,8),(1,9)...(7,15); tw_idx 0..7.
REQ-035 Stage 3 -> reads (0,1),(2,3)...(14,15) with tw_idx all 0; writes repeat the same pairs 2 cycles later.
REQ-036 Full run -> done pulses exactly 40 cycles after acceptance, with 32 rd_en and 32 wr_en cycles and no read of a stage before the previous stage's last write.
REQ-037 Start reasserted at cycles 5 and 40 (during busy and during done) -> ignored, with no second run.
REQ-038 rst_n low for 1 cycle at cycle 13 -> all outputs 0 immediately and no wr_en afterward; a new start then yields a clean 40-cycle run.
REQ-039 Scoreboard run with a RAM model and the BU in the loop -> the memory matches the golden-model N-point DIF result in bit-reversed order.
